bsg_dmc_ui_trace_driver: RTL and testbench

- Upstream neighbour of bsg_dmc_pearl.
- Replays a valid/ready stream of trace entries onto the DMC user interface (app_* command and write-data channels).
- Buffers returned read bursts into a credit-protected FIFO and presents them on a valid/yumi output.
- Replaces ad-hoc UI driving in traffic generators, so FPGA and ASIC test harnesses share one UI-protocol-correct front end.

---
 rtl/bsg_dmc_pearl_pkg.sv | 26 ++
 rtl/bsg_dmc_pkg.sv | 15 +
 rtl/bsg_fifo_1r1w_small.sv | 57 +++++
 rtl/bsg_dmc_ui_trace_driver.sv | 178 +++++++++++++++++
 tb/tb_bsg_dmc_ui_trace_driver.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_dmc_pearl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_dmc_pearl_pkg
// Description : Trace-entry types for the DMC UI trace driver.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_dmc_pearl_pkg;

    typedef enum logic [1:0] {
        TRACE_CMD_WR = 2'd0,
        TRACE_CMD_RD = 2'd1,
        TRACE_DATA   = 2'd2
    } trace_op_e;

    localparam int C_TRACE_ADDR_WIDTH = 28;
    localparam int C_TRACE_DATA_WIDTH = 32;

    // Entry layout for the default UI geometry; other widths slice the same {op, addr, data} order.
    typedef struct packed {
        trace_op_e                      op;
        logic [C_TRACE_ADDR_WIDTH-1:0]  addr;
        logic [C_TRACE_DATA_WIDTH-1:0]  data;
    } trace_entry_s;

endpackage
`default_nettype wire

// File: rtl/bsg_dmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_dmc_pkg
// Description : Shared DMC user-interface types (app_cmd encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_dmc_pkg;

    typedef enum logic [2:0] {
        APP_CMD_WR = 3'b000,
        APP_CMD_RD = 3'b001
    } app_cmd_e;

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fifo_1r1w_small
// Description : Small register FIFO, ready-then-valid input, valid/yumi output.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int WIDTH = 32,
    parameter int ELS   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_yumi
);

    localparam int c_ptr_w = (ELS > 1) ? $clog2(ELS) : 1;
    localparam int c_cnt_w = $clog2(ELS + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(ELS - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(ELS);

    logic [WIDTH-1:0]   r_mem [ELS];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign o_ready = (r_count != c_full_cnt) | i_yumi;
    assign o_v     = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_v & o_ready;
    assign w_pop   = i_yumi & o_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/bsg_dmc_ui_trace_driver.sv
`default_nettype none
// ============================================================================
// Module      : bsg_dmc_ui_trace_driver
// Description : Replays trace entries onto the DMC app_* UI; buffers read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_dmc_ui_trace_driver
    import bsg_dmc_pkg::*;
    import bsg_dmc_pearl_pkg::*;
#(
    parameter int UI_ADDR_WIDTH = 28,
    parameter int UI_DATA_WIDTH = 32,
    parameter int UI_BURST_LEN  = 8,
    parameter int RFIFO_ELS     = 16
) (
    input  logic                          ui_clk_i,
    input  logic                          ui_reset_n_i,
    input  logic                          init_calib_complete_i,
    input  logic                          trace_v_i,
    input  logic [2+UI_ADDR_WIDTH+UI_DATA_WIDTH-1:0] trace_data_i,
    output logic                          trace_ready_o,
    output logic [UI_ADDR_WIDTH-1:0]      app_addr_o,
    output logic [2:0]                    app_cmd_o,
    output logic                          app_en_o,
    input  logic                          app_rdy_i,
    output logic                          app_wdf_wren_o,
    output logic [UI_DATA_WIDTH-1:0]      app_wdf_data_o,
    output logic [(UI_DATA_WIDTH>>3)-1:0] app_wdf_mask_o,
    output logic                          app_wdf_end_o,
    input  logic                          app_wdf_rdy_i,
    input  logic                          app_rd_data_valid_i,
    input  logic [UI_DATA_WIDTH-1:0]      app_rd_data_i,
    input  logic                          app_rd_data_end_i,
    output logic                          rd_v_o,
    output logic [UI_DATA_WIDTH-1:0]      rd_data_o,
    input  logic                          rd_yumi_i,
    output logic [2:0]                    err_o
);

    localparam int c_trace_w = 2 + UI_ADDR_WIDTH + UI_DATA_WIDTH;
    localparam int c_beat_w  = (UI_BURST_LEN > 1) ? $clog2(UI_BURST_LEN) : 1;
    localparam int c_cred_w  = $clog2(RFIFO_ELS + 1);
    localparam logic [c_beat_w-1:0] c_last_beat  = c_beat_w'(UI_BURST_LEN - 1);
    localparam logic [c_cred_w-1:0] c_burst_cred = c_cred_w'(UI_BURST_LEN);
    localparam logic [c_cred_w-1:0] c_full_cred  = c_cred_w'(RFIFO_ELS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;

    if (RFIFO_ELS < UI_BURST_LEN) begin : g_els_check
        $error("RFIFO_ELS must be >= UI_BURST_LEN");
    end

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     r_live;
    logic [UI_ADDR_WIDTH-1:0] r_addr;
    logic                     r_cmd_rd;
    logic [c_cred_w-1:0]      r_credits;
    logic                     r_wren;
    logic                     r_wend;
    logic [UI_DATA_WIDTH-1:0] r_wdata;
    logic [c_beat_w-1:0]      r_beat_cnt;
    logic [c_beat_w-1:0]      r_rd_cnt;
    logic [2:0]               r_err;

    logic [1:0]               w_op;
    logic [UI_ADDR_WIDTH-1:0] w_addr;
    logic [UI_DATA_WIDTH-1:0] w_data;
    logic                     w_trace_fire, w_is_cmd, w_is_data;
    logic                     w_cmd_fire, w_wdf_fire, w_beat_load, w_proto_err, w_rd_grant;
    logic                     w_fifo_ready;

    assign w_op   = trace_data_i[c_trace_w-1 -: 2];
    assign w_addr = trace_data_i[UI_DATA_WIDTH +: UI_ADDR_WIDTH];
    assign w_data = trace_data_i[UI_DATA_WIDTH-1:0];

    assign w_trace_fire = trace_v_i & trace_ready_o;
    assign w_is_cmd     = (w_op == TRACE_CMD_WR) | (w_op == TRACE_CMD_RD);
    assign w_is_data    = (w_op == TRACE_DATA);
    assign w_cmd_fire   = app_en_o & app_rdy_i;
    assign w_wdf_fire   = r_wren & app_wdf_rdy_i;
    assign w_beat_load  = w_trace_fire & (r_state == S_WDATA) & w_is_data;
    assign w_rd_grant   = w_cmd_fire & r_cmd_rd;
    assign w_proto_err  = w_trace_fire & (((r_state == S_IDLE) & ~w_is_cmd) |
                                          ((r_state == S_WDATA) & ~w_is_data));

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trace_fire & w_is_cmd) w_state_nxt = S_CMD;
            S_CMD:   if (w_cmd_fire) w_state_nxt = r_cmd_rd ? S_IDLE : S_WDATA;
            S_WDATA: if (w_wdf_fire & r_wend) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Once the end beat sits in the output register no further entry is taken.
    always_comb begin
        trace_ready_o = 1'b0;
        app_en_o      = 1'b0;
        case (r_state)
            S_IDLE:  trace_ready_o = init_calib_complete_i & r_live;
            S_CMD:   app_en_o      = ~r_cmd_rd | (r_credits >= c_burst_cred);
            S_WDATA: trace_ready_o = (~r_wren | app_wdf_rdy_i) & ~r_wend;
            default: trace_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            r_live     <= 1'b0;
            r_addr     <= '0;
            r_cmd_rd   <= 1'b0;
            r_credits  <= c_full_cred;
            r_wren     <= 1'b0;
            r_wend     <= 1'b0;
            r_wdata    <= '0;
            r_beat_cnt <= '0;
            r_rd_cnt   <= '0;
            r_err      <= '0;
        end else begin
            r_live <= 1'b1;
            if ((r_state == S_IDLE) && w_trace_fire && w_is_cmd) begin
                r_addr     <= w_addr;
                r_cmd_rd   <= (w_op == TRACE_CMD_RD);
                r_beat_cnt <= '0;
            end
            if (w_beat_load) begin
                r_wren     <= 1'b1;
                r_wdata    <= w_data;
                r_wend     <= (r_beat_cnt == c_last_beat);
                r_beat_cnt <= (r_beat_cnt == c_last_beat) ? '0 : r_beat_cnt + c_beat_w'(1);
            end else if (w_wdf_fire) begin
                r_wren <= 1'b0;
                r_wend <= 1'b0;
            end
            // Credits track free FIFO slots not yet promised to an issued read.
            r_credits <= r_credits + c_cred_w'(rd_yumi_i) - (w_rd_grant ? c_burst_cred : '0);
            if (app_rd_data_valid_i) begin
                r_rd_cnt <= (r_rd_cnt == c_last_beat) ? '0 : r_rd_cnt + c_beat_w'(1);
                if (app_rd_data_end_i != (r_rd_cnt == c_last_beat)) r_err[1] <= 1'b1;
                if (!w_fifo_ready) r_err[2] <= 1'b1;
            end
            if (w_proto_err) r_err[0] <= 1'b1;
        end
    end

    bsg_fifo_1r1w_small #(
        .WIDTH (UI_DATA_WIDTH),
        .ELS   (RFIFO_ELS)
    ) u_rfifo (
        .i_clk   (ui_clk_i),
        .i_rst_n (ui_reset_n_i),
        .i_v     (app_rd_data_valid_i),
        .i_data  (app_rd_data_i),
        .o_ready (w_fifo_ready),
        .o_v     (rd_v_o),
        .o_data  (rd_data_o),
        .i_yumi  (rd_yumi_i)
    );

    assign app_addr_o     = r_addr;
    assign app_cmd_o      = r_cmd_rd ? APP_CMD_RD : APP_CMD_WR;
    assign app_wdf_wren_o = r_wren;
    assign app_wdf_data_o = r_wdata;
    assign app_wdf_mask_o = '0;
    assign app_wdf_end_o  = r_wend;
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bsg_dmc_ui_trace_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_dmc_ui_trace_driver
// Description : Directed self-checking bench for bsg_dmc_ui_trace_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_dmc_ui_trace_driver;

    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int BL  = 8;
    localparam int ELS = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_calib;
    logic              trace_v;
    logic [2+AW+DW-1:0] trace_data;
    logic              trace_ready;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic [DW-1:0]     app_wdf_data;
    logic [DW/8-1:0]   app_wdf_mask;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic              rd_valid;
    logic [DW-1:0]     rd_beat;
    logic              rd_end;
    logic              rd_v;
    logic [DW-1:0]     rd_data;
    logic              rd_yumi;
    logic [2:0]        err;

    int checks   = 0;
    int failures = 0;
    int wdf_mode = 0;
    int cmd_cnt  = 0;
    logic [DW+4:0] beat_q [$];

    always #5 clk = ~clk;

    bsg_dmc_ui_trace_driver #(
        .UI_ADDR_WIDTH (AW),
        .UI_DATA_WIDTH (DW),
        .UI_BURST_LEN  (BL),
        .RFIFO_ELS     (ELS)
    ) dut (
        .ui_clk_i              (clk),
        .ui_reset_n_i          (rst_n),
        .init_calib_complete_i (init_calib),
        .trace_v_i             (trace_v),
        .trace_data_i          (trace_data),
        .trace_ready_o         (trace_ready),
        .app_addr_o            (app_addr),
        .app_cmd_o             (app_cmd),
        .app_en_o              (app_en),
        .app_rdy_i             (app_rdy),
        .app_wdf_wren_o        (app_wdf_wren),
        .app_wdf_data_o        (app_wdf_data),
        .app_wdf_mask_o        (app_wdf_mask),
        .app_wdf_end_o         (app_wdf_end),
        .app_wdf_rdy_i         (app_wdf_rdy),
        .app_rd_data_valid_i   (rd_valid),
        .app_rd_data_i         (rd_beat),
        .app_rd_data_end_i     (rd_end),
        .rd_v_o                (rd_v),
        .rd_data_o             (rd_data),
        .rd_yumi_i             (rd_yumi),
        .err_o                 (err)
    );

    // Write-data channel ready: 0 = always ready, 1 = toggle each cycle, 2 = stalled.
    initial begin : wdf_driver
        app_wdf_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (wdf_mode)
                1:       app_wdf_rdy = ~app_wdf_rdy;
                2:       app_wdf_rdy = 1'b0;
                default: app_wdf_rdy = 1'b1;
            endcase
        end
    end

    // Inputs only change just after posedge, so negedge values are the ones the next edge sees.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (app_wdf_wren && app_wdf_rdy) beat_q.push_back({app_wdf_end, app_wdf_mask, app_wdf_data});
            if (app_en && app_rdy) cmd_cnt++;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        trace_v    = 1'b1;
        trace_data = {op, a, d};
        while (!got && n < 200) begin
            @(negedge clk);
            if (trace_ready) got = 1'b1;
            else n++;
        end
        chk("send_accept", 64'(got), 64'd1);
        cyc();
        trace_v    = 1'b0;
        trace_data = '0;
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_q.size() < target && n < 300) begin
            cyc();
            n++;
        end
        chk("beat_count", 64'(beat_q.size()), 64'(target));
    endtask

    task automatic check_burst(input int base, input logic [DW-1:0] dbase);
        logic [DW+4:0] e;
        for (int i = 0; i < BL; i++) begin
            if (base + i < beat_q.size()) e = beat_q[base+i];
            else e = '1;
            chk($sformatf("wbeat%0d_data", i), 64'(e[DW-1:0]), 64'(dbase + DW'(i)));
            chk($sformatf("wbeat%0d_end", i), 64'(e[DW+4]), 64'(i == BL - 1));
            chk($sformatf("wbeat%0d_mask", i), 64'(e[DW+3:DW]), 64'd0);
        end
    endtask

    task automatic rd_burst(input logic [DW-1:0] base, input int end_at);
        for (int i = 0; i < BL; i++) begin
            rd_valid = 1'b1;
            rd_beat  = base + DW'(i);
            rd_end   = (i == end_at);
            cyc();
        end
        rd_valid = 1'b0;
        rd_end   = 1'b0;
        rd_beat  = '0;
    endtask

    initial begin : main
        int base;
        int c0;
        rst_n = 1'b0; init_calib = 1'b0; trace_v = 1'b0; trace_data = '0;
        app_rdy = 1'b0; rd_valid = 1'b0; rd_beat = '0; rd_end = 1'b0; rd_yumi = 1'b0;
        #1;
        chk("rst_trace_ready", 64'(trace_ready), 64'd0);
        chk("rst_app_en", 64'(app_en), 64'd0);
        chk("rst_wren", 64'(app_wdf_wren), 64'd0);
        chk("rst_wend", 64'(app_wdf_end), 64'd0);
        chk("rst_rd_v", 64'(rd_v), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("ready_no_calib", 64'(trace_ready), 64'd0);
        cyc();
        init_calib = 1'b1;
        @(negedge clk);
        chk("ready_calib", 64'(trace_ready), 64'd1);
        cyc();

        // Write with command and data stalls
        wdf_mode = 1;
        app_rdy  = 1'b0;
        base     = beat_q.size();
        send(2'd0, 28'h100, '0);
        repeat (3) begin
            @(negedge clk);
            chk("wr_en_held", 64'(app_en), 64'd1);
            chk("wr_addr_stable", 64'(app_addr), 64'h100);
            chk("wr_cmd", 64'(app_cmd), 64'd0);
        end
        cyc();
        app_rdy = 1'b1;
        for (int i = 0; i < BL; i++) send(2'd2, '0, DW'(i));
        wait_beats(base + BL);
        check_burst(base, 32'h0);
        repeat (3) cyc();
        @(negedge clk);
        chk("wr_done_ready", 64'(trace_ready), 64'd1);
        chk("wr_done_wren", 64'(app_wdf_wren), 64'd0);
        chk("wr_done_en", 64'(app_en), 64'd0);
        cyc();
        wdf_mode = 0;

        // Credit limit: third read must wait for a full burst of pops
        c0 = cmd_cnt;
        send(2'd1, 28'h200, '0);
        send(2'd1, 28'h208, '0);
        send(2'd1, 28'h210, '0);
        repeat (4) cyc();
        chk("rd_cmds_issued_2", 64'(cmd_cnt - c0), 64'd2);
        @(negedge clk);
        chk("rd3_en_blocked", 64'(app_en), 64'd0);
        chk("rd3_cmd", 64'(app_cmd), 64'd1);
        chk("rd3_addr", 64'(app_addr), 64'h210);
        cyc();
        rd_burst(32'hA0, BL - 1);
        chk("rd_return_err", 64'(err), 64'd0);
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            chk($sformatf("rd_v_%0d", i), 64'(rd_v), 64'd1);
            chk($sformatf("rd_data_%0d", i), 64'(rd_data), 64'(32'hA0 + i));
            if (i == 1) chk("rd3_one_yumi_blocked", 64'(app_en), 64'd0);
            cyc();
            rd_yumi = 1'b1;
            cyc();
            rd_yumi = 1'b0;
        end
        @(negedge clk);
        chk("rd3_en_after_8_yumi", 64'(app_en), 64'd1);
        chk("rd_fifo_empty", 64'(rd_v), 64'd0);
        cyc(); cyc();
        chk("rd_cmds_issued_3", 64'(cmd_cnt - c0), 64'd3);
        chk("rd_err_clean", 64'(err), 64'd0);

        // Protocol error: DATA entry while idle
        send(2'd2, 28'h5, 32'h55);
        @(negedge clk);
        chk("proto_err", 64'(err), 64'd1);
        chk("proto_idle_ready", 64'(trace_ready), 64'd1);
        chk("proto_no_en", 64'(app_en), 64'd0);
        cyc();
        base = beat_q.size();
        c0   = cmd_cnt;
        send(2'd0, 28'h300, '0);
        @(negedge clk);
        chk("wr2_en", 64'(app_en), 64'd1);
        chk("wr2_addr", 64'(app_addr), 64'h300);
        chk("wr2_cmd", 64'(app_cmd), 64'd0);
        cyc();
        for (int i = 0; i < BL; i++) send(2'd2, '0, 32'h10 + DW'(i));
        wait_beats(base + BL);
        check_burst(base, 32'h10);
        chk("wr2_cmd_count", 64'(cmd_cnt - c0), 64'd1);

        // Read end flag on the wrong beat
        repeat (2) cyc();
        rd_burst(32'hB0, 5);
        @(negedge clk);
        chk("end_mismatch_err", 64'(err), 64'd3);
        chk("end_mismatch_data", 64'(rd_data), 64'hB0);
        repeat (5) cyc();
        @(negedge clk);
        chk("end_mismatch_sticky", 64'(err), 64'd3);
        cyc();

        // Asynchronous reset in the middle of a write burst
        send(2'd0, 28'h400, '0);
        for (int i = 0; i < 4; i++) send(2'd2, '0, 32'h20 + DW'(i));
        @(negedge clk);
        chk("mid_wren", 64'(app_wdf_wren), 64'd1);
        chk("mid_wdata", 64'(app_wdf_data), 64'h23);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wren", 64'(app_wdf_wren), 64'd0);
        chk("async_wend", 64'(app_wdf_end), 64'd0);
        chk("async_en", 64'(app_en), 64'd0);
        chk("async_ready", 64'(trace_ready), 64'd0);
        chk("async_rd_v", 64'(rd_v), 64'd0);
        chk("async_err", 64'(err), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        chk("post_rst_ready", 64'(trace_ready), 64'd1);
        chk("post_rst_err", 64'(err), 64'd0);
        cyc();
        c0 = cmd_cnt;
        send(2'd1, 28'h500, '0);
        send(2'd1, 28'h508, '0);
        repeat (4) cyc();
        chk("post_rst_full_credits", 64'(cmd_cnt - c0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
